float_to_dec: RTL and testbench

Converts one IEEE754 single-precision result from the trig/arith stages (`sin`, `cos`, etc., NaN pattern 32'hFFC00000 on error) into sign + 4 integer BCD digits + 3 fraction BCD digits for the display driver. Sits directly downstream of `sin`'s `result`/`done`. It is a multi-cycle FSM with fixed latency and a start/done handshake matching the other pipeline stages.

---
 rtl/float_to_dec_pkg.sv | 32 +++
 rtl/float_to_dec_bcd_dabble.sv | 53 +++++
 rtl/float_to_dec.sv | 166 ++++++++++++++++
 tb/tb_float_to_dec.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/float_to_dec_pkg.sv
// Shared widths, constants, FSM encoding and the x10 helper for float_to_dec.
// The 38-bit fixed-point working format is 14 integer bits and 24 fraction bits.
package float_to_dec_pkg;

   localparam int INPUTOUTBIT = 32;
   localparam int INT_DIGITS  = 4;
   localparam int FRAC_DIGITS = 3;
   localparam int F2D_LATENCY = 19;
   localparam int INT_BITS    = 14;
   localparam int FRAC_BITS   = 24;
   localparam int FIXED_BITS  = INT_BITS + FRAC_BITS;

   localparam logic [7:0]  EXP_BIAS     = 8'd127;
   localparam logic [31:0] NAN_PATTERN  = 32'hFFC0_0000;
   localparam logic [3:0]  DABBLE_STEPS = 4'd14;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ALIGN  = 3'd1,
      ST_DABBLE = 3'd2,
      ST_FRAC   = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   // Multiply a 24-bit fraction by ten with shifts and one add.
   function automatic logic [27:0] times_ten(input logic [23:0] x);
      logic [27:0] w;
      w = {4'd0, x};
      return (w << 3) + (w << 1);
   endfunction

endpackage

// File: rtl/float_to_dec_bcd_dabble.sv
// Serial shift-add-3 binary to BCD converter, one input bit per clock.
// done is high during the cycle whose closing edge performs the last step.
module bcd_dabble
   import float_to_dec_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [13:0] bin,
   output logic [15:0] bcd,
   output logic        done
);

   logic [13:0] bin_r;
   logic [15:0] bcd_r;
   logic [3:0]  cnt_r;

   function automatic logic [15:0] add3(input logic [15:0] b);
      logic [15:0] r;
      logic [3:0]  d;
      r = 16'd0;
      for (int i = 0; i < 4; i++) begin
         d = b[i*4 +: 4];
         if (d >= 4'd5) r[i*4 +: 4] = d + 4'd3;
         else           r[i*4 +: 4] = d;
      end
      return r;
   endfunction

   logic [15:0] adj_s;
   assign adj_s = add3(bcd_r);

   // Shift register and step counter for the conversion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_r <= 14'd0;
         bcd_r <= 16'd0;
         cnt_r <= 4'd0;
      end else if (load) begin
         bin_r <= bin;
         bcd_r <= 16'd0;
         cnt_r <= DABBLE_STEPS;
      end else if (cnt_r != 4'd0) begin
         bcd_r <= {adj_s[14:0], bin_r[13]};
         bin_r <= {bin_r[12:0], 1'b0};
         cnt_r <= cnt_r - 4'd1;
      end
   end

   assign bcd  = bcd_r;
   assign done = (cnt_r == 4'd1);

endmodule

// File: rtl/float_to_dec.sv
// IEEE754 single to sign + 4 integer BCD digits + 3 truncated fraction digits.
// Fixed 19-cycle start-to-done latency regardless of error/overflow.
module float_to_dec
   import float_to_dec_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [INPUTOUTBIT-1:0]   value,
   output logic                     sign,
   output logic [4*INT_DIGITS-1:0]  int_bcd,
   output logic [4*FRAC_DIGITS-1:0] frac_bcd,
   output logic                     overflow,
   output logic                     error,
   output logic                     busy,
   output logic                     done
);

   state_t            state_r, state_n;
   logic [31:0]       value_r;
   logic [23:0]       frac_r;
   logic [11:0]       frac_digits_r;
   logic [1:0]        frac_cnt_r;
   logic              ovf_r;
   logic              err_r;

   logic [7:0]        exp_s;
   logic [23:0]       sig_s;
   logic [FIXED_BITS-1:0] fixed_s;
   logic              ovf_s;
   logic [27:0]       prod_s;
   logic              dab_done_s;
   logic [15:0]       dab_bcd_s;

   assign exp_s  = value_r[30:23];
   assign sig_s  = {1'b1, value_r[22:0]};
   assign prod_s = times_ten(frac_r);

   // Place the significand's leading one at weight 2^(e-127) in the 14.24 format.
   always_comb begin
      fixed_s = '0;
      if (exp_s == 8'd0 || exp_s == 8'd255) begin
         fixed_s = '0;
      end else if (exp_s < EXP_BIAS - 8'd24) begin
         fixed_s = '0;
      end else if (exp_s > EXP_BIAS + 8'd13) begin
         fixed_s = '0;
      end else if (exp_s >= EXP_BIAS - 8'd1) begin
         fixed_s = {14'd0, sig_s} << (exp_s - (EXP_BIAS - 8'd1));
      end else begin
         fixed_s = {14'd0, sig_s} >> ((EXP_BIAS - 8'd1) - exp_s);
      end
   end

   assign ovf_s = ((exp_s > EXP_BIAS + 8'd13) && (exp_s != 8'd255))
                  || (fixed_s[37:24] > 14'd9999);

   bcd_dabble u_dabble (
      .clk  (clk),
      .rst  (rst),
      .load (state_r == ST_ALIGN),
      .bin  (fixed_s[37:24]),
      .bcd  (dab_bcd_s),
      .done (dab_done_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_n = ST_ALIGN;
            else       state_n = ST_IDLE;
         end
         ST_ALIGN:  state_n = ST_DABBLE;
         ST_DABBLE: begin
            if (dab_done_s) state_n = ST_FRAC;
            else            state_n = ST_DABBLE;
         end
         ST_FRAC: begin
            if (frac_cnt_r == 2'd2) state_n = ST_OUT;
            else                    state_n = ST_FRAC;
         end
         ST_OUT:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_r       <= 32'd0;
         frac_r        <= 24'd0;
         frac_digits_r <= 12'd0;
         frac_cnt_r    <= 2'd0;
         ovf_r         <= 1'b0;
         err_r         <= 1'b0;
         sign          <= 1'b0;
         int_bcd       <= '0;
         frac_bcd      <= '0;
         overflow      <= 1'b0;
         error         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  value_r <= value;
                  busy    <= 1'b1;
               end
            end
            ST_ALIGN: begin
               frac_r        <= fixed_s[23:0];
               ovf_r         <= ovf_s;
               err_r         <= (exp_s == 8'd255);
               frac_cnt_r    <= 2'd0;
               frac_digits_r <= 12'd0;
            end
            ST_DABBLE: begin
               frac_cnt_r <= 2'd0;
            end
            ST_FRAC: begin
               frac_r        <= prod_s[23:0];
               frac_digits_r <= {frac_digits_r[7:0], prod_s[27:24]};
               frac_cnt_r    <= frac_cnt_r + 2'd1;
            end
            ST_OUT: begin
               done <= 1'b1;
               busy <= 1'b0;
               if (err_r) begin
                  sign     <= 1'b0;
                  int_bcd  <= '0;
                  frac_bcd <= '0;
                  overflow <= 1'b0;
                  error    <= 1'b1;
               end else if (ovf_r) begin
                  sign     <= value_r[31];
                  int_bcd  <= 16'h9999;
                  frac_bcd <= 12'h999;
                  overflow <= 1'b1;
                  error    <= 1'b0;
               end else begin
                  // A result that prints as all zeros is shown unsigned.
                  sign     <= value_r[31] && ((dab_bcd_s != 16'd0) || (frac_digits_r != 12'd0));
                  int_bcd  <= dab_bcd_s;
                  frac_bcd <= frac_digits_r;
                  overflow <= 1'b0;
                  error    <= 1'b0;
               end
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_dec.sv
// Self-checking bench for float_to_dec: directed and random values against
// an arithmetic reference model, plus latency, busy, ignored-start and reset checks.
module tb_float_to_dec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] value = 32'd0;
   logic        sign;
   logic [15:0] int_bcd;
   logic [11:0] frac_bcd;
   logic        overflow;
   logic        error;
   logic        busy;
   logic        done;

   int cmp_count = 0;
   int fail_count = 0;

   float_to_dec dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .value    (value),
      .sign     (sign),
      .int_bcd  (int_bcd),
      .frac_bcd (frac_bcd),
      .overflow (overflow),
      .error    (error),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Value = sig * 2^(e-150); the 24-bit fraction is floor(x * 2^24), digits truncated.
   function automatic void ref_model(input logic [31:0] v, output logic s, output logic [15:0] ib,
                                     output logic [11:0] fb, output logic ov, output logic er);
      int unsigned e;
      longint unsigned sig, f, ip, fd;
      e   = v[30:23];
      sig = {40'd0, 1'b1, v[22:0]};
      s = 1'b0; ib = 16'h0; fb = 12'h0; ov = 1'b0; er = (e == 255);
      if (!er) begin
         if (e == 0)        f = 0;
         else if (e >= 141) f = 0;
         else if (e >= 126) f = sig << (e - 126);
         else if (126 - e >= 40) f = 0;
         else               f = sig >> (126 - e);
         ip = f >> 24;
         fd = ((f & 64'hFF_FFFF) * 1000) >> 24;
         ov = (e >= 141) || (ip > 9999);
         if (ov) begin
            s = v[31]; ib = 16'h9999; fb = 12'h999;
         end else begin
            ib[15:12] = 4'(ip / 1000 % 10);
            ib[11:8]  = 4'(ip / 100 % 10);
            ib[7:4]   = 4'(ip / 10 % 10);
            ib[3:0]   = 4'(ip % 10);
            fb[11:8]  = 4'(fd / 100 % 10);
            fb[7:4]   = 4'(fd / 10 % 10);
            fb[3:0]   = 4'(fd % 10);
            s = v[31] && (ip != 0 || fd != 0);
         end
      end
   endfunction

   // mode 0: plain conversion; 1: extra start while busy; 2: reset at T+10.
   task automatic run_conv(input logic [31:0] v, input int mode);
      logic es, eov, eer;
      logic [15:0] eib;
      logic [11:0] efb;
      int lat, extra;
      ref_model(v, es, eib, efb, eov, eer);
      @(negedge clk);
      value = v;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         @(posedge clk);
         #1;
         if (mode == 1 && i == 4) begin start = 1'b1; value = ~v; end
         if (mode == 1 && i == 5) start = 1'b0;
         if (mode == 2 && i == 10) begin
            rst = 1'b1;
            #1;
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_outs", {sign, overflow, error, 1'b0, int_bcd, frac_bcd}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            extra = 0;
            for (int j = 0; j < 25; j++) begin
               @(posedge clk);
               #1;
               if (done) extra++;
            end
            check("rst_no_done", extra, 0);
            check("rst_idle_busy", {31'd0, busy}, 32'd0);
            return;
         end
         if (i == 10) check("busy_mid", {31'd0, busy}, 32'd1);
         if (done) lat = i;
      end
      check("latency", lat, 19);
      check("sign", {31'd0, sign}, {31'd0, es});
      check("int_bcd", {16'd0, int_bcd}, {16'd0, eib});
      check("frac_bcd", {20'd0, frac_bcd}, {20'd0, efb});
      check("overflow", {31'd0, overflow}, {31'd0, eov});
      check("error", {31'd0, error}, {31'd0, eer});
      @(posedge clk);
      #1;
      check("done_pulse", {31'd0, done}, 32'd0);
      check("busy_after", {31'd0, busy}, 32'd0);
      if (mode == 1) begin
         extra = 0;
         for (int j = 0; j < 25; j++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
         end
         check("ignored_start", extra, 0);
      end
   endtask

   initial begin
      logic [31:0] rv;
      logic [7:0]  re;
      #1;
      check("reset_outs", {sign, overflow, error, busy, int_bcd, frac_bcd}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_conv(32'h3F00_0000, 0);
      check("half_frac", {20'd0, frac_bcd}, 32'h500);
      run_conv(32'hBF80_0000, 0);
      check("neg_one", {sign, 3'd0, int_bcd, frac_bcd}, {1'b1, 3'd0, 16'h0001, 12'h000});
      run_conv(32'h42F6_E979, 0);
      check("123_456", {int_bcd, 4'd0, frac_bcd}, {16'h0123, 4'd0, 12'h456});
      run_conv(32'h3A83_126F, 0);
      check("milli_trunc", {sign, 19'd0, frac_bcd}, {20'd0, 12'h000});
      run_conv(32'h461C_4000, 0);
      check("ten_thousand", {overflow, 3'd0, int_bcd, frac_bcd}, {1'b1, 3'd0, 16'h9999, 12'h999});
      run_conv(32'hFFC0_0000, 0);
      check("nan", {error, overflow, sign, 1'b0, int_bcd, frac_bcd}, {4'b1000, 28'd0});
      run_conv(32'h8000_0000, 0);
      run_conv(32'h7F80_0000, 0);
      run_conv(32'hC61C_3FFC, 0);
      run_conv(32'h4000_0000, 1);
      run_conv(32'h4049_0FDB, 2);
      run_conv(32'h4049_0FDB, 0);

      for (int n = 0; n < 40; n++) begin
         rv = $urandom;
         case ($urandom_range(0, 3))
            0: re = rv[30:23];
            1: re = 8'($urandom_range(100, 145));
            2: re = 8'($urandom_range(118, 140));
            default: re = (rv[0]) ? 8'd0 : 8'd255;
         endcase
         rv[30:23] = re;
         run_conv(rv, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
